// File: rtl/bus_fifo_out_pkg.sv
// Shared bus-responder definitions: register offsets and bus FSM state encodings.
// Reused by any responder that speaks the read/write strobe, ready_r/ready_w handshake.
package bus_fifo_out_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAckR,
    StAckW,
    StStallW
  } bus_state_e;

endpackage

// File: rtl/bus_fifo_out_fifo_sync.sv
// Single-clock FIFO with occupancy count; a pop in the same cycle frees a slot for a push
// into a full FIFO. Head word reads as zero while empty.
module bus_fifo_out_fifo_sync #(
  parameter int unsigned width      = 16,
  parameter int unsigned depth_addr = 3,
  parameter int unsigned depth      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      rdata,
  output logic [depth_addr:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CW = depth_addr + 1;
  localparam logic [depth_addr-1:0] PtrInc = depth_addr'(1);
  localparam logic [CW-1:0] CntInc = CW'(1);
  localparam logic [CW-1:0] CntMax = CW'(depth);

  logic [width-1:0]      mem_q [depth];
  logic [depth_addr-1:0] wptr_q, wptr_d;
  logic [depth_addr-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntMax);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrInc;
    if (pop_ok)  rptr_d = rptr_q + PtrInc;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntInc;
      2'b01:   count_d = count_q - CntInc;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty count masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/bus_fifo_out.sv
// CPU-bus output FIFO: DATA register (address 0) pushes words, STATUS (address 1) reports
// count/full/empty. Optional drain interrupt and threshold register under BUS_FIFO_OUT_IRQ_EN.
module bus_fifo_out
  import bus_fifo_out_pkg::*;
#(
  parameter int unsigned width      = 16,
  parameter int unsigned depth_addr = 3,
  parameter int unsigned depth      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  output logic             ready_r,
  output logic             ready_w,
  input  logic             address,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out,
  output logic             port_valid,
  output logic [width-1:0] port_data,
`ifdef BUS_FIFO_OUT_IRQ_EN
  output logic             irq,
`endif
  input  logic             port_ack
);

  localparam int unsigned CW = depth_addr + 1;

  bus_state_e       state_q, state_d;
  logic [width-1:0] data_out_q, data_out_d;
  logic [width-1:0] head, status;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop, can_push;

  assign pop      = !empty && port_ack;
  assign can_push = !full || pop;

  bus_fifo_out_fifo_sync #(
    .width     (width),
    .depth_addr(depth_addr),
    .depth     (depth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(data_in),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

`ifdef BUS_FIFO_OUT_IRQ_EN
  logic [CW-1:0] thr_q, thr_d;
  logic          irq_q, irq_d;

  assign irq_d = (count <= thr_q) && (thr_q != '0);
  assign irq   = irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      thr_q <= thr_d;
      irq_q <= irq_d;
    end
  end
`endif

  always_comb begin
    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[CW+1:2] = count;
`ifdef BUS_FIFO_OUT_IRQ_EN
    status[2*depth_addr+3 -: CW] = thr_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    push       = 1'b0;
`ifdef BUS_FIFO_OUT_IRQ_EN
    thr_d      = thr_q;
`endif
    case (state_q)
      StIdle: begin
        if (read) begin
          data_out_d = (address == REG_STATUS) ? status : head;
          state_d    = StAckR;
        end else if (write) begin
          if (address == REG_DATA) begin
            if (can_push) begin
              push    = 1'b1;
              state_d = StAckW;
            end else begin
              state_d = StStallW;
            end
          end else begin
`ifdef BUS_FIFO_OUT_IRQ_EN
            thr_d   = data_in[CW-1:0];
`endif
            state_d = StAckW;
          end
        end
      end
      StStallW: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = StAckW;
        end
      end
      StAckR:  state_d = StIdle;
      StAckW:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
    end
  end

  assign ready_r    = (state_q == StAckR);
  assign ready_w    = (state_q == StAckW);
  assign data_out   = data_out_q;
  assign port_valid = !empty;
  assign port_data  = head;

endmodule

// File: doc/bus_fifo_out.md
Name: bus_fifo_out

Overview:
- Memory-mapped responder on the CPU bus. Same strobe/ready handshake as the ram and gpio responders: read/write strobes in, ready_r/ready_w pulses out.
- The CPU pushes 16-bit words into an internal FIFO.
- An external consumer drains the FIFO through a valid/ack port.
- Occupies two bus words, decoded by the system address logic. Replaces gpio_out where buffered output is needed.

Parameters:
- width, 16, data word width (bus and port)
- depth_addr, 3, log2 of FIFO depth
- depth, 8, FIFO depth in words; must equal 2**depth_addr

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- read  input  1  CPU read strobe, held until ready_r seen
- write  input  1  CPU write strobe, held until ready_w seen
- ready_r  output  1  one-cycle read acknowledge
- ready_w  output  1  one-cycle write acknowledge
- address  input  1  0 = DATA register, 1 = STATUS register
- data_in  input  width  CPU write data
- data_out  output  width  CPU read data, valid while ready_r is high
- port_valid  output  1  FIFO non-empty; port_data holds the head word
- port_data  output  width  head of FIFO
- port_ack  input  1  consumer pops the head when port_valid && port_ack

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; read/write pointers and count = 0; FSM = IDLE.
  - ready_r = 0, ready_w = 0, data_out = 0, port_valid = 0, port_data = 0.
- Bus FSM states: IDLE, ACK_R, ACK_W, STALL_W.
- IDLE, read high:
  - Capture data_out and go to ACK_R.
  - address 0: data_out = head word, no pop (0 if empty).
  - address 1: data_out = {zero pad, count[depth_addr:0], full, empty}; full in bit 1, empty in bit 0, count from bit 2.
- IDLE, write high, address 0:
  - Not full: push data_in, go to ACK_W.
  - Full: go to STALL_W, no push.
- IDLE, write high, address 1: no effect on FIFO, go to ACK_W.
- Read and write both high in IDLE: read wins; write is handled next time IDLE sees it.
- STALL_W: each cycle, if not full (or a pop happens this cycle), push data_in and go to ACK_W. Otherwise stay, ready_w = 0.
- ACK_R / ACK_W:
  - ready_r / ready_w high for exactly this one cycle, then IDLE.
  - The CPU deasserts its strobe in the cycle it sees ready.
  - Minimum latency: 1 cycle from strobe sampled to ready.
- Consumer side:
  - port_valid = (count != 0), registered from state.
  - Pop when port_valid && port_ack at a clock edge.
  - port_ack while empty is ignored.
- Simultaneous push and pop:
  - Both take effect; count unchanged.
  - When full, a same-cycle pop frees a slot for the stalled push.
- Pointers wrap modulo depth. count is depth_addr+1 bits, range 0..depth.
- full = (count == depth), empty = (count == 0).
- Reset mid-operation (including STALL_W) aborts the transfer. No ready is issued and FIFO contents are discarded.

Optional Feature:
- Macro: BUS_FIFO_OUT_IRQ_EN
- Enabled:
  - Adds output irq (1 bit) and a depth_addr+1-bit threshold register (reset 0).
  - A write to address 1 loads threshold from data_in[depth_addr:0].
  - irq is registered, high when count <= threshold and threshold != 0; it tells the CPU the FIFO has drained.
  - STATUS read returns threshold in bits [2*depth_addr+3 : depth_addr+3].
- Disabled: no irq port; writes to address 1 are acknowledged and ignored; those STATUS bits read 0.

Decomposition:
- Shared include bus_defs.v: bus register offset constants (REG_DATA = 0, REG_STATUS = 1) and FSM state encodings; reused by future bus responders.
- One sub-module fifo_sync: storage array, pointers, count, full/empty, simultaneous push/pop.
- bus_fifo_out holds the bus FSM, register decode and the optional irq logic.

Test Plan:
- Reset low mid-write, release -> all outputs 0; STATUS read returns 16'h0001 (empty).
- Write 16'h1234 then 16'hABCD to address 0 -> ready_w pulses 1 cycle after each strobe; port_valid = 1, port_data = 16'h1234; ack -> port_data = 16'hABCD; second ack -> port_valid = 0.
- Write 8 words 16'h0001..16'h0008 -> STATUS = 16'h0022 (count 8, full). 9th write stalls with ready_w low. Ack once -> 9th write completes within 1 cycle, port_data = 16'h0002.
- Full FIFO, port_ack held high while the CPU streams writes -> push and pop in the same cycle; count stays at 8; output order matches write order across pointer wrap.
- Read and write strobes both high in IDLE at address 1 -> ready_r first, then ready_w on a later cycle; FIFO unchanged.
- With BUS_FIFO_OUT_IRQ_EN: threshold = 2, fill 5 words, drain -> irq rises the cycle after count becomes 2; STATUS threshold field = 2.
